// File: rtl/iram_arb_pkg.sv
// iram_arb_pkg
//   Shared encodings and default sizing for the instruction-RAM arbiter.
//   arb_state_t : ST_BOOT holds fetch off while the loader writes the image,
//                 ST_RUN arbitrates per cycle with fetch priority.
//   rsp_own_t   : which port owns the read response that is in flight.
package iram_arb_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LOAD  = 1'b1
    } rsp_own_t;

    localparam int ADDR_W_DEF     = 12;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 8;
    localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/iram_arbiter.sv
// iram_arbiter
//   Shares one single-port instruction RAM between the core fetch port
//   (read-only) and a loader/debug port (read/write, byte enables).
//   BOOT: fetch is held off, loader always wins. boot_done moves to RUN,
//   which is sticky until reset. RUN: fetch has priority, but a loader that
//   has been denied STARVE_MAX consecutive cycles wins the next one.
//
// Handshake: a requester holds req and its command fields stable until it
//   sees gnt high in a cycle; gnt is combinational and the access is issued
//   to the RAM in that same cycle. A read returns rvalid/rdata exactly one
//   cycle after its grant; writes never return rvalid.
//
// Ports
//   sclk, rstn          clock, asynchronous active-low reset
//   boot_done           loader finished; BOOT->RUN on the next edge
//   boot_active         1 while in BOOT (observes the FSM state)
//   f_req/f_addr        fetch read request and byte address
//   f_gnt/f_rvalid/f_rdata   fetch grant and read response
//   l_req/l_we/l_be/l_addr/l_wdata   loader command
//   l_gnt/l_rvalid/l_rdata   loader grant and read response
//   ram_cs/ram_we/ram_addr/ram_wdata   RAM command (word address)
//   ram_rdata           RAM read data, valid the cycle after a read access
module iram_arbiter
    import iram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                sclk,
    input  logic                rstn,
    input  logic                boot_done,
    output logic                boot_active,
    input  logic                f_req,
    input  logic [31:0]         f_addr,
    output logic                f_gnt,
    output logic                f_rvalid,
    output logic [DATA_W-1:0]   f_rdata,
    input  logic                l_req,
    input  logic                l_we,
    input  logic [DATA_W/8-1:0] l_be,
    input  logic [31:0]         l_addr,
    input  logic [DATA_W-1:0]   l_wdata,
    output logic                l_gnt,
    output logic                l_rvalid,
    output logic [DATA_W-1:0]   l_rdata,
    output logic                ram_cs,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             starved;
    logic             rsp_pend;
    rsp_own_t         rsp_own;

    // Byte-offset and alias bits of the byte addresses are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                                l_addr[31:ADDR_W+2], l_addr[1:0]};

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_BOOT;
            starve_cnt <= '0;
            rsp_pend   <= 1'b0;
            rsp_own    <= OWN_FETCH;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            // Only reads leave a response behind; the tag says who gets it.
            rsp_pend   <= f_gnt | (l_gnt & ~l_we);
            rsp_own    <= l_gnt ? OWN_LOAD : OWN_FETCH;
        end
    end

    always_comb begin
        state_nxt  = state;
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        starve_nxt = '0;
        starved    = (starve_cnt == STARVE_LIM);

        if (state == ST_BOOT) begin
            l_gnt = l_req;
            if (boot_done) begin
                state_nxt = ST_RUN;
            end
        end else begin
            l_gnt = l_req & (~f_req | starved);
            f_gnt = f_req & ~l_gnt;
            // Count only consecutive denials; any grant or idle cycle clears it.
            if (l_req && !l_gnt) begin
                starve_nxt = starved ? starve_cnt : starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ram_cs    = f_gnt | l_gnt;
        ram_addr  = l_gnt ? l_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
        ram_we    = (l_gnt & l_we) ? l_be : '0;
        ram_wdata = l_gnt ? l_wdata : '0;
    end

    assign boot_active = (state == ST_BOOT);
    assign f_rvalid    = rsp_pend & (rsp_own == OWN_FETCH);
    assign l_rvalid    = rsp_pend & (rsp_own == OWN_LOAD);
    assign f_rdata     = ram_rdata;
    assign l_rdata     = ram_rdata;

endmodule

// File: tb/tb_iram_arbiter.sv
// tb_iram_arbiter
//   Drives the fetch and loader ports of iram_arbiter against a behavioural
//   4096x32 RAM. A reference model tracks state, starvation and memory
//   contents; read responses are queued at grant time and compared when the
//   arbiter returns them.
module tb_iram_arbiter;

    logic        sclk;
    logic        rstn;
    logic        boot_done;
    logic        boot_active;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req;
    logic        l_we;
    logic [3:0]  l_be;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        ram_cs;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    iram_arbiter dut (
        .sclk        (sclk),
        .rstn        (rstn),
        .boot_done   (boot_done),
        .boot_active (boot_active),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_gnt       (f_gnt),
        .f_rvalid    (f_rvalid),
        .f_rdata     (f_rdata),
        .l_req       (l_req),
        .l_we        (l_we),
        .l_be        (l_be),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_gnt       (l_gnt),
        .l_rvalid    (l_rvalid),
        .l_rdata     (l_rdata),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // ---------------- clock / reset ----------------
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // ---------------- counters and checker ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // ---------------- behavioural RAM ----------------
    logic [31:0] mem [0:4095];
    logic [31:0] mem_w;

    always @(posedge sclk) begin
        if (ram_cs) begin
            mem_w = mem[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem_w[8*b +: 8] = ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
            mem[ram_addr] <= mem_w;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [0:4095];
    logic [32:0] exp_q[$];          // {owner is loader, data}
    bit          m_run;
    int          m_starve;
    logic        eg_f, eg_l;
    logic [11:0] idx;
    logic [32:0] e;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        ram_rdata = '0;
        m_run     = 1'b0;
        m_starve  = 0;
    end

    always @(negedge sclk) begin
        if (!rstn) begin
            exp_q.delete();
            m_run    = 1'b0;
            m_starve = 0;
            check("rst_f_rvalid", f_rvalid, 0);
            check("rst_l_rvalid", l_rvalid, 0);
            check("rst_f_gnt", f_gnt, 0);
            check("rst_ram_cs", ram_cs, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_boot_active", boot_active, 1);
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e[32]) begin
                    check("mon_l_rvalid", l_rvalid, 1);
                    check("mon_l_rdata", l_rdata, e[31:0]);
                    check("mon_f_rvalid_idle", f_rvalid, 0);
                end else begin
                    check("mon_f_rvalid", f_rvalid, 1);
                    check("mon_f_rdata", f_rdata, e[31:0]);
                    check("mon_l_rvalid_idle", l_rvalid, 0);
                end
            end else begin
                check("mon_f_rvalid_none", f_rvalid, 0);
                check("mon_l_rvalid_none", l_rvalid, 0);
            end

            check("mon_boot_active", boot_active, {31'd0, !m_run});

            if (!m_run) begin
                eg_l = l_req;
                eg_f = 1'b0;
            end else begin
                eg_l = l_req && (!f_req || m_starve == 8);
                eg_f = f_req && !eg_l;
            end
            check("mon_f_gnt", f_gnt, eg_f);
            check("mon_l_gnt", l_gnt, eg_l);
            check("mon_ram_cs", ram_cs, eg_f | eg_l);
            check("mon_ram_we", ram_we, (eg_l && l_we) ? l_be : 4'h0);
            check("mon_ram_wdata", ram_wdata, eg_l ? l_wdata : 32'h0);

            idx = eg_l ? l_addr[13:2] : f_addr[13:2];
            if (eg_l || eg_f) check("mon_ram_addr", ram_addr, idx);
            if (eg_l && l_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (l_be[b]) ref_mem[idx][8*b +: 8] = l_wdata[8*b +: 8];
                end
            end else if (eg_l || eg_f) begin
                exp_q.push_back({eg_l, ref_mem[idx]});
            end

            if (m_run && l_req && !eg_l) m_starve = (m_starve == 8) ? 8 : m_starve + 1;
            else m_starve = 0;
            if (!m_run && boot_done) m_run = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic settle();
        @(negedge sclk);
        #1;
    endtask

    task automatic f_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        n = 0;
        step();
        f_req  = 1'b1;
        f_addr = a;
        settle();
        while (!f_gnt && n < 50) begin
            step();
            settle();
            n++;
        end
        check("f_read_gnt", f_gnt, 1);
        step();
        f_req = 1'b0;
        settle();
        check("f_read_rvalid", f_rvalid, 1);
        d = f_rdata;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    int          win_at [2];
    int          wins;
    logic        rv_hist [64];
    logic [31:0] rd_hist [64];
    logic        fg_hist [64];

    initial begin
        rstn      = 1'b1;
        boot_done = 1'b0;
        f_req     = 1'b0;
        f_addr    = '0;
        l_req     = 1'b0;
        l_we      = 1'b0;
        l_be      = '0;
        l_addr    = '0;
        l_wdata   = '0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge sclk);
        #1 rstn = 1'b1;

        // BOOT: loader wins even with fetch requesting
        step();
        f_req = 1'b1; f_addr = 32'h10;
        l_req = 1'b1; l_we = 1'b1; l_be = 4'hF; l_addr = 32'h10; l_wdata = 32'hDEADBEEF;
        settle();
        check("boot_f_gnt", f_gnt, 0);
        check("boot_l_gnt", l_gnt, 1);
        check("boot_ram_we", ram_we, 4'hF);
        check("boot_ram_addr", ram_addr, 12'h004);
        step();
        l_req = 1'b0; l_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("boot_hold_f_gnt", f_gnt, 0);
            step();
        end
        boot_done = 1'b1;
        settle();
        check("boot_done_cycle_f_gnt", f_gnt, 0);
        step();
        boot_done = 1'b0;

        // RUN read of the image word
        settle();
        check("run_f_gnt", f_gnt, 1);
        check("run_boot_active", boot_active, 0);
        step();
        f_req = 1'b0;
        settle();
        check("run_f_rvalid", f_rvalid, 1);
        check("run_f_rdata", f_rdata, 32'hDEADBEEF);

        // partial write then read back
        step();
        l_req = 1'b1; l_we = 1'b1; l_be = 4'b0010; l_addr = 32'h10; l_wdata = 32'h0000AB00;
        settle();
        check("pw_l_gnt", l_gnt, 1);
        check("pw_ram_we", ram_we, 4'b0010);
        step();
        l_req = 1'b0; l_we = 1'b0;
        settle();
        check("pw_no_l_rvalid", l_rvalid, 0);
        f_read(32'h10, rd);
        check("pw_readback", rd, 32'hDEADABEF);

        // back-to-back fetch reads
        step();
        f_req = 1'b1; f_addr = 32'h0;
        step();
        f_addr = 32'h4;
        settle();
        check("b2b_rv0", f_rvalid, 1);
        check("b2b_rd0", f_rdata, init_word(0));
        step();
        f_addr = 32'h8;
        settle();
        check("b2b_rv1", f_rvalid, 1);
        check("b2b_rd1", f_rdata, init_word(1));
        step();
        f_req = 1'b0;
        settle();
        check("b2b_rv2", f_rvalid, 1);
        check("b2b_rd2", f_rdata, init_word(2));
        check("b2b_no_l_rvalid", l_rvalid, 0);

        // starvation: two rounds with fetch held; counter must restart after a win
        step();
        f_req = 1'b1; f_addr = 32'h0;
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20;
        wins = 0;
        win_at[0] = -1;
        win_at[1] = -1;
        for (int c = 0; c < 40 && wins < 2; c++) begin
            settle();
            rv_hist[c] = l_rvalid;
            rd_hist[c] = l_rdata;
            fg_hist[c] = f_gnt;
            if (l_gnt) begin
                win_at[wins] = c;
                wins++;
            end
            step();
            if (wins == 1) l_addr = 32'h24;
            if (wins == 2) begin
                l_req = 1'b0;
                f_req = 1'b0;
            end
        end
        settle();
        check("starve_wins", wins, 2);
        check("starve_win0_at", win_at[0], 8);
        check("starve_win1_at", win_at[1], 17);
        if (wins == 2 && win_at[0] == 8 && win_at[1] == 17) begin
            check("starve_f_gnt_win0", fg_hist[8], 0);
            check("starve_f_gnt_win1", fg_hist[17], 0);
            check("starve_l_rvalid0", rv_hist[9], 1);
            check("starve_l_rdata0", rd_hist[9], init_word(8));
        end
        check("starve_l_rvalid1", l_rvalid, 1);
        check("starve_l_rdata1", l_rdata, init_word(9));

        // random traffic, checked cycle by cycle by the model
        for (int i = 0; i < 300; i++) begin
            step();
            f_req   = ($urandom_range(0, 3) != 0);
            l_req   = $urandom_range(0, 1);
            l_we    = $urandom_range(0, 1);
            l_be    = 4'($urandom_range(0, 15));
            f_addr  = $urandom;
            l_addr  = $urandom;
            l_wdata = $urandom;
        end
        step();
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        step();
        settle();
        check("queue_drained", exp_q.size(), 0);

        // reset while a fetch read is outstanding
        step();
        f_req = 1'b1; f_addr = 32'h20;
        settle();
        check("mid_f_gnt", f_gnt, 1);
        rstn = 1'b0;
        step();
        f_req = 1'b0;
        settle();
        check("mid_f_rvalid", f_rvalid, 0);
        check("mid_boot_active", boot_active, 1);
        step();
        rstn  = 1'b1;
        f_req = 1'b1;
        settle();
        check("mid_after_f_gnt", f_gnt, 0);
        check("mid_after_f_rvalid", f_rvalid, 0);
        check("mid_after_boot_active", boot_active, 1);
        step();
        f_req = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
